reg_bank_sb: RTL and testbench
==============================

REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register data width in bits (>=1).
REQ-002 SHALL have parameter NREGS, default 4, number of registers (>=2); AW = ceil(log2(NREGS)) is a derived local constant.
REQ-003 SHALL have parameter R0_ZERO, default 0, where 1 hardwires register 0 to zero.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports wr_en/wr_addr/wr_data, input, 1/AW/WIDTH, write request.
REQ-008 SHALL have ports rsv_en/rsv_addr, input, 1/AW, mark a register pending (result in flight).
REQ-009 SHALL have ports rs_addr/rt_addr, input, AW each, read-port addresses.
REQ-010 SHALL have ports rs_data/rt_data, output, WIDTH each, registered read data.
REQ-011 SHALL have ports rs_pend/rt_pend, output, 1 each, registered pending flag of the addressed register.
REQ-012 SHALL have ports clr_req (input, 1), request a full clear, and ready (output, 1), bank accepting operations.

Function
REQ-013 SHALL implement FSM states CLEAR and RUN; ready=1 only in RUN.
REQ-014 In CLEAR, each cycle SHALL zero reg[idx] and pend[idx], then increment idx; after idx=NREGS-1, SHALL go to RUN (ready rises NREGS cycles after entry).
REQ-015 clr_req sampled high in RUN SHALL enter CLEAR with idx=0 next cycle; clr_req in CLEAR SHALL be ignored (no restart).
REQ-016 In CLEAR, wr_en and rsv_en SHALL be ignored; rs/rt_data and rs/rt_pend SHALL be driven 0.
REQ-017 In RUN, wr_en=1 SHALL store wr_data in reg[wr_addr] and clear pend[wr_addr] at the edge.
REQ-018 In RUN, rsv_en=1 SHALL set pend[rsv_addr] at the edge; write and reserve to the same address in one cycle SHALL leave pend=1 with the data written.
REQ-019 Read latency SHALL be 1 cycle: the outputs after edge k reflect the addresses sampled at edge k.
REQ-020 Read SHALL bypass: a same-cycle write to the read address SHALL return wr_data, and the pend output SHALL show the post-edge pending value.
REQ-021 rs and rt SHALL be independent; equal addresses SHALL return identical values.
REQ-022 With R0_ZERO=1, writes/reserves to address 0 SHALL be dropped; reads of 0 SHALL return data 0 and pend 0.
REQ-023 Addresses >= NREGS (non-power-of-2 NREGS) SHALL ignore writes/reserves and read as data 0, pend 0.

Reset
REQ-024 reset=1 at an edge SHALL force CLEAR, idx=0, ready=0, rs/rt_data=0, rs/rt_pend=0; registers are then zeroed by the sweep.
REQ-025 reset mid-sweep or mid-operation SHALL restart the sweep from idx=0; reset SHALL take priority over clr_req, wr_en and rsv_en.

Structure
REQ-026 The FSM state encoding (CLEAR, RUN) and default parameter values SHALL live in shared package reg_bank_pkg.
REQ-027 The bypass/mux read logic SHALL be a sub-module reg_bank_rdport, instantiated twice (rs, rt).

Verification (WIDTH=8, NREGS=4, R0_ZERO=0 unless stated)
REQ-028 Release reset -> ready=0 for 4 cycles then 1; every register reads 0x00, pend 0.
REQ-029 Write r2=0xA5 with rs_addr=2 in the same cycle -> rs_data=0xA5 next cycle (bypass); rt_addr=2 on the following cycle -> 0xA5.
REQ-030 rsv r1 -> rs_pend=1 for addr 1; then write r1=0x3C -> pend 0, data 0x3C; write+rsv r1 in the same cycle -> data written, pend 1.
REQ-031 Fill r0..r3 = 0x11..0x44, pulse clr_req -> ready=0 for 4 cycles, writes during the sweep dropped, all read 0x00 after.
REQ-032 Assert reset at sweep idx=2 -> sweep restarts, ready low for 4 further cycles.
REQ-033 R0_ZERO=1, NREGS=3: write r0=0xFF and r3=0x77 -> both read 0x00, pend 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants for the scoreboard register bank: default parameters and FSM encoding.
package reg_bank_pkg;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NREGS   = 4;
  localparam int DEF_R0_ZERO = 0;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port with write/reserve bypass; output shows post-edge bank contents.
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter int R0_ZERO = DEF_R0_ZERO,
  parameter int AW      = $clog2(DEF_NREGS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        zero,
  input  logic [AW-1:0]               addr,
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic [NREGS-1:0]            pend,
  input  logic                        we,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rv,
  input  logic [AW-1:0]               rsv_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_pend
);
  logic [WIDTH-1:0] data_nx;
  logic             pend_nx;

  // Addresses with no backing register fall through the loop and read as zero.
  always_comb begin
    data_nx = '0;
    pend_nx = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == AW'(i)) begin
        data_nx = regs[i];
        pend_nx = pend[i];
      end
    end
    if (we && (wr_addr == addr)) begin
      data_nx = wr_data;
      pend_nx = 1'b0;
    end
    if (rv && (rsv_addr == addr)) pend_nx = 1'b1;
    if ((R0_ZERO != 0) && (addr == '0)) begin
      data_nx = '0;
      pend_nx = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || zero) begin
      rd_data <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_data <= data_nx;
      rd_pend <= pend_nx;
    end
  end
endmodule

// File: rtl/reg_bank_sb.sv
// Register bank with per-register pending (scoreboard) bits and a sequential clear sweep.
// ready=1 means every input sampled at the next edge is acted on; while ready=0 writes/reserves are dropped.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter int R0_ZERO = DEF_R0_ZERO,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic             rs_pend,
  output logic             rt_pend,
  input  logic             clr_req,
  output logic             ready,
  output logic [0:0]       state_dbg
);
  logic [0:0]                  state;
  logic [AW-1:0]               idx;
  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            pend;
  logic                        run, we, rv, rd_zero;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  assign run       = (state == ST_RUN);
  assign ready     = run;
  assign state_dbg = state;
  assign we        = run && wr_en && addr_ok(wr_addr);
  assign rv        = run && rsv_en && addr_ok(rsv_addr);
  // Reads go quiet on any edge whose next state is CLEAR (or that is still sweeping).
  assign rd_zero   = !run || clr_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else if (!run) begin
      for (int i = 0; i < NREGS; i++) begin
        if (idx == AW'(i)) begin
          regs[i] <= '0;
          pend[i] <= 1'b0;
        end
      end
      if (int'(idx) == NREGS - 1) begin
        state <= ST_RUN;
        idx   <= '0;
      end else begin
        idx <= idx + AW'(1);
      end
    end else begin
      if (clr_req) begin
        state <= ST_CLEAR;
        idx   <= '0;
      end
      // Reserve is applied after write so a same-cycle write+reserve leaves pend set.
      for (int i = 0; i < NREGS; i++) begin
        if (we && (wr_addr == AW'(i))) begin
          regs[i] <= wr_data;
          pend[i] <= 1'b0;
        end
        if (rv && (rsv_addr == AW'(i))) pend[i] <= 1'b1;
      end
    end
  end

  reg_bank_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .R0_ZERO(R0_ZERO), .AW(AW)) u_rs (
    .clock(clock), .reset(reset), .zero(rd_zero), .addr(rs_addr), .regs(regs), .pend(pend),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rv(rv), .rsv_addr(rsv_addr),
    .rd_data(rs_data), .rd_pend(rs_pend)
  );

  reg_bank_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .R0_ZERO(R0_ZERO), .AW(AW)) u_rt (
    .clock(clock), .reset(reset), .zero(rd_zero), .addr(rt_addr), .regs(regs), .pend(pend),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rv(rv), .rsv_addr(rsv_addr),
    .rd_data(rt_data), .rd_pend(rt_pend)
  );
endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: directed scenarios plus random traffic against a behavioural bank model.
module tb_reg_bank_sb;
  localparam int NR = 4;

  logic       clock = 1'b0;
  logic       reset, wr_en, rsv_en, clr_req, ready;
  logic [1:0] wr_addr, rsv_addr, rs_addr, rt_addr;
  logic [7:0] wr_data, rs_data, rt_data;
  logic       rs_pend, rt_pend;
  logic [0:0] state_dbg;

  logic       b_reset, b_wr_en, b_rsv_en, b_clr_req, b_ready;
  logic [1:0] b_wr_addr, b_rsv_addr, b_rs_addr, b_rt_addr;
  logic [7:0] b_wr_data, b_rs_data, b_rt_data;
  logic       b_rs_pend, b_rt_pend;
  logic [0:0] b_state_dbg;

  always #5 clock = ~clock;

  reg_bank_sb #(.WIDTH(8), .NREGS(4), .R0_ZERO(0)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rs_pend(rs_pend), .rt_pend(rt_pend),
    .clr_req(clr_req), .ready(ready), .state_dbg(state_dbg)
  );

  reg_bank_sb #(.WIDTH(8), .NREGS(3), .R0_ZERO(1)) dut3 (
    .clock(clock), .reset(b_reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
    .rs_data(b_rs_data), .rt_data(b_rt_data), .rs_pend(b_rs_pend), .rt_pend(b_rt_pend),
    .clr_req(b_clr_req), .ready(b_ready), .state_dbg(b_state_dbg)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: bank contents plus a count of remaining clear cycles.
  logic [7:0] m_mem [NR];
  logic       m_pend[NR];
  int         clear_left = NR;
  logic [7:0] e_rs_d, e_rt_d;
  logic       e_rs_p, e_rt_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_total++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = 8'h00;
      m_pend[i] = 1'b0;
    end
    clear_left = NR;
  endtask

  // One clock: advance the model on the edge, then check the main DUT 1ns later.
  task automatic cyc();
    @(posedge clock);
    e_rs_d = 8'h00; e_rt_d = 8'h00; e_rs_p = 1'b0; e_rt_p = 1'b0;
    if (reset) begin
      model_clear();
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (clr_req) begin
      model_clear();
    end else begin
      if (wr_en) begin
        m_mem[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (rsv_en) m_pend[rsv_addr] = 1'b1;
      e_rs_d = m_mem[rs_addr]; e_rs_p = m_pend[rs_addr];
      e_rt_d = m_mem[rt_addr]; e_rt_p = m_pend[rt_addr];
    end
    #1;
    check("ready", 32'(ready), 32'(clear_left == 0));
    check("rs_data", 32'(rs_data), 32'(e_rs_d));
    check("rs_pend", 32'(rs_pend), 32'(e_rs_p));
    check("rt_data", 32'(rt_data), 32'(e_rt_d));
    check("rt_pend", 32'(rt_pend), 32'(e_rt_p));
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0; rs_addr = '0; rt_addr = '0;
    b_reset = 1'b1; b_wr_en = 1'b0; b_rsv_en = 1'b0; b_clr_req = 1'b0;
    b_wr_addr = '0; b_wr_data = '0; b_rsv_addr = '0; b_rs_addr = '0; b_rt_addr = '0;
    model_clear();

    cyc(); cyc();
    check("reset_ready_low", 32'(ready), 32'(0));
    reset = 1'b0; b_reset = 1'b0;
    repeat (3) begin
      cyc();
      check("sweep_ready_low", 32'(ready), 32'(0));
    end
    cyc();
    check("ready_after_sweep", 32'(ready), 32'(1));
    for (int i = 0; i < NR; i++) begin
      rs_addr = 2'(i); rt_addr = 2'(NR - 1 - i);
      cyc();
    end

    // Bypass on a same-cycle write, then a plain read on the other port.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; rs_addr = 2'd2; rt_addr = 2'd0;
    cyc();
    check("bypass_rs", 32'(rs_data), 32'hA5);
    wr_en = 1'b0; rt_addr = 2'd2;
    cyc();
    check("read_rt", 32'(rt_data), 32'hA5);

    rsv_en = 1'b1; rsv_addr = 2'd1; rs_addr = 2'd1;
    cyc();
    check("rsv_pend", 32'(rs_pend), 32'(1));
    rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
    cyc();
    check("wr_clears_pend", 32'(rs_pend), 32'(0));
    check("wr_data_r1", 32'(rs_data), 32'h3C);
    rsv_en = 1'b1; wr_data = 8'h5E;
    cyc();
    check("wr_rsv_data", 32'(rs_data), 32'h5E);
    check("wr_rsv_pend", 32'(rs_pend), 32'(1));
    idle_inputs();

    // Fill, clear with writes attempted mid-sweep, then read back zeros.
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 8'(8'h11 * (i + 1));
      cyc();
    end
    wr_en = 1'b0; clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < NR - 1; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 8'hEE; clr_req = 1'b1;
      cyc();
      check("clr_ready_low", 32'(ready), 32'(0));
    end
    idle_inputs();
    cyc();
    check("clr_ready_high", 32'(ready), 32'(1));
    for (int i = 0; i < NR; i++) begin
      rs_addr = 2'(i); rt_addr = 2'(i);
      cyc();
      check("post_clr_zero", 32'(rs_data), 32'h00);
    end

    // Reset arriving with the sweep at idx 2 restarts the full sweep.
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (3) begin
      cyc();
      check("restart_ready_low", 32'(ready), 32'(0));
    end
    cyc();
    check("restart_ready_high", 32'(ready), 32'(1));

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      clr_req  = ($urandom_range(0, 39) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      rsv_en   = ($urandom_range(0, 2) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      rsv_addr = 2'($urandom_range(0, 3));
      rs_addr  = 2'($urandom_range(0, 3));
      rt_addr  = ($urandom_range(0, 3) == 0) ? rs_addr : 2'($urandom_range(0, 3));
      wr_data  = 8'($urandom);
      cyc();
    end
    reset = 1'b0; idle_inputs();
    repeat (6) cyc();

    // Three-register bank with r0 hardwired to zero.
    check("b_ready", 32'(b_ready), 32'(1));
    b_wr_en = 1'b1; b_wr_addr = 2'd0; b_wr_data = 8'hFF; b_rs_addr = 2'd0; b_rt_addr = 2'd0;
    cyc();
    check("b_r0_rs", 32'(b_rs_data), 32'h00);
    check("b_r0_rt", 32'(b_rt_data), 32'h00);
    b_wr_addr = 2'd3; b_wr_data = 8'h77; b_rsv_en = 1'b1; b_rsv_addr = 2'd3; b_rs_addr = 2'd3;
    cyc();
    check("b_r3_data", 32'(b_rs_data), 32'h00);
    check("b_r3_pend", 32'(b_rs_pend), 32'(0));
    b_wr_addr = 2'd1; b_wr_data = 8'h5A; b_rsv_addr = 2'd0; b_rs_addr = 2'd1; b_rt_addr = 2'd0;
    cyc();
    check("b_r1_data", 32'(b_rs_data), 32'h5A);
    check("b_r0_pend", 32'(b_rt_pend), 32'(0));
    b_wr_en = 1'b0; b_rsv_en = 1'b0; b_rs_addr = 2'd3; b_rt_addr = 2'd0;
    cyc();
    check("b_r3_idle", 32'(b_rs_data), 32'h00);
    check("b_r0_idle", 32'(b_rt_data), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
